// File: rtl/ldpc_layer_scheduler.sv
// ldpc_layer_scheduler
//   Layered LDPC decoder sequencer. Walks the base-graph ROM one layer at a
//   time: reads each layer's entries (issuing APP RAM reads with the read-side
//   shift), waits out the check-node latency, then replays the same entries as
//   APP RAM writes with the inverse (right) shift. Repeats the whole graph until
//   the iteration limit or the early-stop flag.
//
// Ports
//   clk_i, reset_n_i            clock, synchronous active-low reset
//   start_i                     frame start pulse (ignored while busy_o)
//   max_iter_i                  iteration limit, latched on start (0 -> 1)
//   early_stop_i                syndrome-ok, sampled at the end of the last layer
//   tbl_addr_o / tbl_data_i     base-graph ROM port, data one cycle after address
//                               tbl_data_i = {last_layer, last_in_layer, col[6:0], shift[8:0]}
//   app_rd_en_o/addr/shift_sel  APP read port + read shifter select
//   app_wr_en_o/addr/rightshift APP write port + write shifter select
//   busy_o, iteration_o, decode_over_o, deg_err_o   status
module ldpc_layer_scheduler #(
   parameter int Z       = 384,
   parameter int MAX_DEG = 19,
   parameter int CNU_LAT = 4
) (
   input  logic        clk_i,
   input  logic        reset_n_i,
   input  logic        start_i,
   input  logic [4:0]  max_iter_i,
   input  logic        early_stop_i,
   output logic [10:0] tbl_addr_o,
   input  logic [17:0] tbl_data_i,
   output logic        app_rd_en_o,
   output logic [6:0]  app_rd_addr_o,
   output logic [8:0]  app_shift_sel_o,
   output logic        app_wr_en_o,
   output logic [6:0]  app_wr_addr_o,
   output logic [8:0]  app_rightshift_sel_o,
   output logic        busy_o,
   output logic [4:0]  iteration_o,
   output logic        decode_over_o,
   output logic        deg_err_o
);

   typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_WRITE, S_NEXT, S_DONE} state_t;

   localparam int CW = $clog2(MAX_DEG + 1);
   localparam int WW = (CNU_LAT > 2) ? $clog2(CNU_LAT) : 1;

   state_t         state_q, state_d;
   logic [10:0]    tbl_addr_q, tbl_addr_d;
   logic           dv_q, dv_d;          // tbl_data_i holds a live entry this cycle
   logic           drain_q, drain_d;    // last read of the layer is on the APP port
   logic [CW-1:0]  cnt_q, cnt_d;        // entries buffered in this layer
   logic [CW-1:0]  wr_idx_q, wr_idx_d;
   logic [WW-1:0]  wcnt_q, wcnt_d;
   logic           last_layer_q, last_layer_d;
   logic [4:0]     lim_q, lim_d;
   logic [4:0]     iter_q, iter_d;
   logic           deg_err_q, deg_err_d;
   logic           rd_en_q, rd_en_d;
   logic [6:0]     rd_addr_q, rd_addr_d;
   logic [8:0]     shift_sel_q, shift_sel_d;
   logic           wr_en_q, wr_en_d;
   logic [6:0]     wr_addr_q, wr_addr_d;
   logic [8:0]     rsel_q, rsel_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic           buf_we;
   logic [15:0]    buf_q [MAX_DEG];     // {col, shift} in arrival order

   logic           e_ll, e_lil, stop_now, iter_done;
   logic [6:0]     e_col;
   logic [8:0]     e_shift;

   assign e_ll    = tbl_data_i[17];
   assign e_lil   = tbl_data_i[16];
   assign e_col   = tbl_data_i[15:9];
   assign e_shift = tbl_data_i[8:0];

   // A full buffer without a last flag closes the layer anyway.
   assign stop_now  = dv_q && (e_lil || (cnt_q == CW'(MAX_DEG - 1)));
   assign iter_done = (({1'b0, iter_q} + 6'd1) >= {1'b0, lim_q}) || early_stop_i;

   // Inverse shift: (Z - shift) mod Z, with out-of-range shifts reduced first.
   function automatic logic [8:0] rsel_f(input logic [8:0] sh);
      int unsigned m;
      m = 32'(sh) % 32'(Z);
      return (m == 0) ? 9'd0 : 9'(32'(Z) - m);
   endfunction

   // state + output registers
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q      <= S_IDLE;
         tbl_addr_q   <= '0;
         dv_q         <= 1'b0;
         drain_q      <= 1'b0;
         cnt_q        <= '0;
         wr_idx_q     <= '0;
         wcnt_q       <= '0;
         last_layer_q <= 1'b0;
         lim_q        <= '0;
         iter_q       <= '0;
         deg_err_q    <= 1'b0;
         rd_en_q      <= 1'b0;
         rd_addr_q    <= '0;
         shift_sel_q  <= '0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         rsel_q       <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         tbl_addr_q   <= tbl_addr_d;
         dv_q         <= dv_d;
         drain_q      <= drain_d;
         cnt_q        <= cnt_d;
         wr_idx_q     <= wr_idx_d;
         wcnt_q       <= wcnt_d;
         last_layer_q <= last_layer_d;
         lim_q        <= lim_d;
         iter_q       <= iter_d;
         deg_err_q    <= deg_err_d;
         rd_en_q      <= rd_en_d;
         rd_addr_q    <= rd_addr_d;
         shift_sel_q  <= shift_sel_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         rsel_q       <= rsel_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (buf_we) buf_q[cnt_q] <= tbl_data_i[15:0];
   end

   // next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start_i) state_d = S_READ;
         S_READ:  if (drain_q) state_d = (CNU_LAT <= 1) ? S_WRITE : S_WAIT;
         S_WAIT:  if (wcnt_q == WW'(CNU_LAT - 2)) state_d = S_WRITE;
         S_WRITE: if (wr_idx_q == cnt_q) state_d = S_NEXT;
         S_NEXT:  state_d = (last_layer_q && iter_done) ? S_DONE : S_READ;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // datapath / registered-output next values
   always_comb begin
      tbl_addr_d   = tbl_addr_q;
      dv_d         = 1'b0;
      drain_d      = 1'b0;
      cnt_d        = cnt_q;
      wr_idx_d     = '0;
      wcnt_d       = '0;
      last_layer_d = last_layer_q;
      lim_d        = lim_q;
      iter_d       = iter_q;
      deg_err_d    = deg_err_q;
      rd_en_d      = 1'b0;
      rd_addr_d    = rd_addr_q;
      shift_sel_d  = shift_sel_q;
      wr_en_d      = 1'b0;
      wr_addr_d    = wr_addr_q;
      rsel_d       = rsel_q;
      buf_we       = 1'b0;
      busy_d       = (state_d != S_IDLE);
      done_d       = (state_d == S_DONE);

      unique case (state_q)
         S_IDLE: begin
            if (start_i) begin
               lim_d      = (max_iter_i == 5'd0) ? 5'd1 : max_iter_i;
               iter_d     = '0;
               deg_err_d  = 1'b0;
               tbl_addr_d = '0;
            end
         end
         S_READ: begin
            // On the closing entry the address already points one past it
            // (the overshoot request), so holding it is the rewind.
            if (!drain_q) begin
               dv_d = !stop_now;
               if (!stop_now) tbl_addr_d = tbl_addr_q + 11'd1;
            end
            drain_d = stop_now;
            if (dv_q) begin
               buf_we      = 1'b1;
               cnt_d       = cnt_q + 1'b1;
               rd_en_d     = 1'b1;
               rd_addr_d   = e_col;
               shift_sel_d = e_shift;
               if (stop_now) begin
                  last_layer_d = e_ll;
                  if (!e_lil) deg_err_d = 1'b1;
               end
            end
         end
         S_WAIT: wcnt_d = wcnt_q + 1'b1;
         S_NEXT: begin
            if (last_layer_q) begin
               iter_d = iter_q + 5'd1;
               if (!iter_done) tbl_addr_d = '0;
            end
         end
         default: ;
      endcase

      // Writes are registered against the next state so they line up with WRITE.
      if (state_d == S_WRITE) begin
         wr_en_d   = 1'b1;
         wr_addr_d = buf_q[wr_idx_q][15:9];
         rsel_d    = rsel_f(buf_q[wr_idx_q][8:0]);
         wr_idx_d  = wr_idx_q + 1'b1;
      end

      if ((state_q != S_READ) && (state_d == S_READ)) cnt_d = '0;
   end

   assign tbl_addr_o           = tbl_addr_q;
   assign app_rd_en_o          = rd_en_q;
   assign app_rd_addr_o        = rd_addr_q;
   assign app_shift_sel_o      = shift_sel_q;
   assign app_wr_en_o          = wr_en_q;
   assign app_wr_addr_o        = wr_addr_q;
   assign app_rightshift_sel_o = rsel_q;
   assign busy_o               = busy_q;
   assign iteration_o          = iter_q;
   assign decode_over_o        = done_q;
   assign deg_err_o            = deg_err_q;

endmodule

// File: tb/tb_ldpc_layer_scheduler.sv
module tb_ldpc_layer_scheduler;
   localparam int Z = 384, MAX_DEG = 19, CNU_LAT = 4;

   logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0, early_stop = 1'b0;
   logic [4:0]  max_iter = '0;
   logic [10:0] tbl_addr;
   logic [17:0] tbl_data = '0;
   logic        app_rd_en, app_wr_en, busy, decode_over, deg_err;
   logic [6:0]  app_rd_addr, app_wr_addr;
   logic [8:0]  app_shift_sel, app_rightshift_sel;
   logic [4:0]  iteration;
   logic [52:0] all_outs;

   int checks = 0, errors = 0;
   int cyc = 0, start_cyc = 0, last_rd_cyc = 0, done_cnt = 0;
   bit mon_on = 0, prev_wr = 0;

   logic [17:0] rom [0:2047];
   logic [15:0] got_rd[$], got_wr[$], exp_rd[$], exp_wr[$];
   int          rd_cyc[$];
   int          exp_iter;
   bit          exp_deg;

   ldpc_layer_scheduler #(.Z(Z), .MAX_DEG(MAX_DEG), .CNU_LAT(CNU_LAT)) dut (
      .clk_i(clk), .reset_n_i(reset_n), .start_i(start), .max_iter_i(max_iter),
      .early_stop_i(early_stop), .tbl_addr_o(tbl_addr), .tbl_data_i(tbl_data),
      .app_rd_en_o(app_rd_en), .app_rd_addr_o(app_rd_addr), .app_shift_sel_o(app_shift_sel),
      .app_wr_en_o(app_wr_en), .app_wr_addr_o(app_wr_addr),
      .app_rightshift_sel_o(app_rightshift_sel), .busy_o(busy), .iteration_o(iteration),
      .decode_over_o(decode_over), .deg_err_o(deg_err));

   assign all_outs = {tbl_addr, app_rd_en, app_rd_addr, app_shift_sel, app_wr_en, app_wr_addr,
                      app_rightshift_sel, busy, iteration, decode_over, deg_err};

   always #5 clk = ~clk;
   always @(posedge clk) tbl_data <= rom[tbl_addr];
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // collect APP traffic; check port exclusivity and the read->write latency
   always @(negedge clk) begin
      if (decode_over) done_cnt++;
      if (mon_on) begin
         chk("rd_wr_excl", 64'(app_rd_en & app_wr_en), 0);
         if (app_rd_en) begin
            got_rd.push_back({app_rd_addr, app_shift_sel});
            rd_cyc.push_back(cyc);
            last_rd_cyc = cyc;
         end
         if (app_wr_en) begin
            got_wr.push_back({app_wr_addr, app_rightshift_sel});
            if (!prev_wr) chk("cnu_gap", 64'(cyc - last_rd_cyc), CNU_LAT);
         end
      end
      prev_wr = app_wr_en;
   end

   function automatic logic [17:0] ent(bit ll, bit lil, int col, int sh);
      return {ll, lil, 7'(col), 9'(sh)};
   endfunction

   function automatic logic [8:0] ref_rsel(int sh);
      return 9'(((Z - sh) % Z + Z) % Z);
   endfunction

   task automatic clear_rom();
      foreach (rom[i]) rom[i] = '0;
   endtask

   // Walk the table layer by layer as the decoder should.
   task automatic model(input int mi, input bit es);
      int addr, lim, n;
      logic [17:0] e;
      addr = 0;
      lim = (mi == 0) ? 1 : mi;
      exp_rd.delete(); exp_wr.delete();
      exp_iter = 0; exp_deg = 0;
      for (int guard = 0; guard < 1000; guard++) begin
         n = 0;
         do begin
            e = rom[addr + n];
            n++;
            exp_rd.push_back(e[15:0]);
            exp_wr.push_back({e[15:9], ref_rsel(int'(e[8:0]))});
            if (!e[16] && n == MAX_DEG) exp_deg = 1;
         end while (!e[16] && n < MAX_DEG);
         addr += n;
         if (e[17]) begin
            exp_iter++;
            if (exp_iter >= lim || es) break;
            addr = 0;
         end
      end
   endtask

   task automatic run_frame(input int mi, input bit es, input int poke_at, input string nm);
      bit seen;
      int nmin;
      seen = 0;
      model(mi, es);
      @(negedge clk);
      got_rd.delete(); got_wr.delete(); rd_cyc.delete(); done_cnt = 0;
      max_iter = 5'(mi); early_stop = es; start = 1'b1;
      @(negedge clk);
      start = 1'b0; start_cyc = cyc; max_iter = 5'($urandom);
      chk({nm, "_busy_hi"}, 64'(busy), 1);
      for (int n = 0; n < 5000 && !seen; n++) begin
         if (decode_over) seen = 1;
         else begin
            if (n == poke_at) begin start = 1'b1; max_iter = 5'd31; end
            @(negedge clk);
            start = 1'b0;
         end
      end
      chk({nm, "_done_seen"}, 64'(seen), 1);
      chk({nm, "_busy_at_done"}, 64'(busy), 1);
      chk({nm, "_iter"}, 64'(iteration), 64'(exp_iter));
      chk({nm, "_deg_err"}, 64'(deg_err), 64'(exp_deg));
      @(negedge clk);
      chk({nm, "_busy_lo"}, 64'(busy), 0);
      chk({nm, "_ndone"}, 64'(done_cnt), 1);
      chk({nm, "_nrd"}, 64'(got_rd.size()), 64'(exp_rd.size()));
      chk({nm, "_nwr"}, 64'(got_wr.size()), 64'(exp_wr.size()));
      nmin = (got_rd.size() < exp_rd.size()) ? got_rd.size() : exp_rd.size();
      for (int i = 0; i < nmin; i++) chk({nm, "_rd"}, 64'(got_rd[i]), 64'(exp_rd[i]));
      nmin = (got_wr.size() < exp_wr.size()) ? got_wr.size() : exp_wr.size();
      for (int i = 0; i < nmin; i++) chk({nm, "_wr"}, 64'(got_wr[i]), 64'(exp_wr[i]));
   endtask

   task automatic table1();
      clear_rom();
      rom[0] = ent(0, 0, 0, 0);
      rom[1] = ent(0, 0, 1, 5);
      rom[2] = ent(0, 1, 2, 383);
      rom[3] = ent(0, 0, 3, 7);
      rom[4] = ent(0, 0, 4, 100);
      rom[5] = ent(1, 1, 5, 200);
   endtask

   task automatic rand_table();
      int nl, a, d;
      clear_rom();
      nl = $urandom_range(1, 4);
      a = 0;
      for (int l = 0; l < nl; l++) begin
         d = $urandom_range(1, MAX_DEG);
         for (int k = 0; k < d; k++) begin
            rom[a] = ent(l == nl - 1 && k == d - 1, k == d - 1,
                         $urandom_range(0, 127), $urandom_range(0, 511));
            a++;
         end
      end
   endtask

   initial begin
      bit hit;
      clear_rom();
      repeat (3) @(negedge clk);
      chk("reset_outs", 64'(all_outs), 0);
      reset_n = 1'b1;
      mon_on = 1;
      repeat (3) @(negedge clk);
      chk("idle_quiet", 64'({busy, app_rd_en, app_wr_en}), 0);

      // two degree-3 layers, two iterations
      table1();
      run_frame(2, 0, -1, "t1");
      chk("t1_nrdcyc", 64'(rd_cyc.size()), 12);
      if (rd_cyc.size() >= 3) begin
         chk("t1_rd0_cyc", 64'(rd_cyc[0] - start_cyc), 2);
         chk("t1_rd1_cyc", 64'(rd_cyc[1] - start_cyc), 3);
         chk("t1_rd2_cyc", 64'(rd_cyc[2] - start_cyc), 4);
      end
      if (got_wr.size() >= 3) begin
         chk("t1_rsel0", 64'(got_wr[0][8:0]), 0);
         chk("t1_rsel1", 64'(got_wr[1][8:0]), 379);
         chk("t1_rsel2", 64'(got_wr[2][8:0]), 1);
      end

      run_frame(2, 1, -1, "t1_es");
      run_frame(0, 0, -1, "mi0");
      run_frame(2, 0, 7, "poke");
      run_frame(3, 0, 30, "poke2");

      // 20-entry layer with no flag: first 19 close the layer, 20th stands alone
      clear_rom();
      for (int i = 0; i < 19; i++) rom[i] = ent(0, 0, i, 3 * i + 1);
      rom[19] = ent(1, 1, 77, 450);
      run_frame(1, 0, -1, "deg");

      // reset during the first iteration's write phase
      table1();
      @(negedge clk);
      max_iter = 5'd2; early_stop = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      hit = 0;
      for (int n = 0; n < 200 && !hit; n++) begin
         if (app_wr_en) hit = 1;
         else @(negedge clk);
      end
      chk("rst_reach_wr", 64'(hit), 1);
      chk("rst_wr_iter", 64'(iteration), 0);
      mon_on = 0;
      reset_n = 1'b0;
      @(negedge clk);
      chk("rst_mid_outs", 64'(all_outs), 0);
      @(negedge clk);
      reset_n = 1'b1;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         chk("rst_quiet", 64'({busy, app_rd_en, app_wr_en, tbl_addr}), 0);
      end
      mon_on = 1;
      run_frame(2, 0, -1, "after_rst");

      for (int f = 0; f < 20; f++) begin
         rand_table();
         run_frame($urandom_range(0, 3), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 60)) : -1, "rnd");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
